// File: rtl/fp_mac_pkg.sv
// ---------------------------------------------------------------------------
// fp_mac_pkg
// Shared types and constants for the fp_mac dot-product sequencer and benches.
//   FP16_W / FP32_W   : operand and accumulator widths
//   FP32_ZERO         : +0.0 in fp32, the starting value of every running sum
//   seq_state_t       : sequencer FSM states
//   FP16_ONE/TWO/THREE: handy fp16 constants (1.0, 2.0, 3.0)
// ---------------------------------------------------------------------------
package fp_mac_pkg;

    localparam int FP16_W = 16;
    localparam int FP32_W = 32;

    localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0000_0000;

    localparam logic [FP16_W-1:0] FP16_ONE   = 16'h3C00;
    localparam logic [FP16_W-1:0] FP16_TWO   = 16'h4000;
    localparam logic [FP16_W-1:0] FP16_THREE = 16'h4200;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/fp_mac_seq_mac_lat_timer.sv
// ---------------------------------------------------------------------------
// mac_lat_timer
// Load/countdown counter that measures the fp_mac pipeline latency.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : load i_load_val (takes priority over counting)
//   i_load_val     : cycles to wait
//   i_dec          : count down this cycle (ignored when the count is zero)
//   o_expire       : high in the cycle whose closing edge takes the count 1->0
// ---------------------------------------------------------------------------
module mac_lat_timer
    import fp_mac_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_expire
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Combinational so the FSM can act on the very edge that empties the counter.
    assign o_expire = i_dec && (r_count == CNT_W'(1));

endmodule

// File: rtl/fp_mac_seq.sv
// ---------------------------------------------------------------------------
// fp_mac_seq
// Dot-product sequencer for the pipelined fp_mac datapath. Accepts fp16 operand
// pairs over valid/ready, issues one pair at a time to fp_mac with the running
// sum on C, waits MAC_LAT cycles for Y, and after vec_len elements presents the
// fp32 sum on o_result with a one-cycle o_done pulse.
// Ports:
//   i_clock, i_resetn : clock, asynchronous active-low reset
//   i_start, i_vec_len: start a run (sampled in IDLE only); length latched at start
//   o_busy            : high in every state except IDLE
//   i_in_valid, o_in_ready, i_in_a, i_in_b : operand pair handshake
//   o_mac_a, o_mac_b, o_mac_c : registered operands to fp_mac
//   i_mac_y           : fp_mac result
//   o_done, o_result  : completion pulse and final sum
// Optional (macro FP_MAC_SEQ_PERF_EN):
//   o_perf_cycles     : busy cycles of the last/current run, saturating
//   o_stall_cycles    : ISSUE cycles without in_valid, saturating
// ---------------------------------------------------------------------------
module fp_mac_seq
    import fp_mac_pkg::*;
#(
    parameter int MAC_LAT = 4,
    parameter int LEN_W   = 8
) (
    input  logic              i_clock,
    input  logic              i_resetn,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_vec_len,
    output logic              o_busy,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [FP16_W-1:0] i_in_a,
    input  logic [FP16_W-1:0] i_in_b,
    output logic [FP16_W-1:0] o_mac_a,
    output logic [FP16_W-1:0] o_mac_b,
    output logic [FP32_W-1:0] o_mac_c,
    input  logic [FP32_W-1:0] i_mac_y,
    output logic              o_done,
    output logic [FP32_W-1:0] o_result
`ifdef FP_MAC_SEQ_PERF_EN
    ,
    output logic [15:0]       o_perf_cycles,
    output logic [15:0]       o_stall_cycles
`endif
);

    localparam logic [3:0] LAT_VAL = 4'(MAC_LAT);

    seq_state_t        r_state;
    logic [FP32_W-1:0] r_acc;
    logic [LEN_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  r_len;
    logic [FP16_W-1:0] r_mac_a;
    logic [FP16_W-1:0] r_mac_b;
    logic [FP32_W-1:0] r_mac_c;
    logic [FP32_W-1:0] r_result;
    logic              r_done;
    logic              r_busy;
    logic              r_in_ready;

    logic              w_accept;
    logic              w_expire;
    logic [LEN_W:0]    w_cnt_inc;

    assign w_accept  = (r_state == ISSUE) && i_in_valid;
    // One extra bit so vec_len = 2^LEN_W-1 compares without wrapping.
    assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;

    mac_lat_timer #(
        .CNT_W (4)
    ) u_timer (
        .i_clk      (i_clock),
        .i_rst_n    (i_resetn),
        .i_load     (w_accept),
        .i_load_val (LAT_VAL),
        .i_dec      (r_state == WAIT),
        .o_expire   (w_expire)
    );

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state    <= IDLE;
            r_acc      <= FP32_ZERO;
            r_cnt      <= '0;
            r_len      <= '0;
            r_mac_a    <= '0;
            r_mac_b    <= '0;
            r_mac_c    <= FP32_ZERO;
            r_result   <= FP32_ZERO;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_acc  <= FP32_ZERO;
                        r_cnt  <= '0;
                        r_len  <= i_vec_len;
                        r_busy <= 1'b1;
                        if (i_vec_len == '0) begin
                            r_state  <= DONE;
                            r_done   <= 1'b1;
                            r_result <= FP32_ZERO;
                        end else begin
                            r_state    <= ISSUE;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (i_in_valid) begin
                        r_mac_a    <= i_in_a;
                        r_mac_b    <= i_in_b;
                        r_mac_c    <= r_acc;
                        r_in_ready <= 1'b0;
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    // mac ports stay frozen: fp_mac samples C through its own buffer.
                    if (w_expire) begin
                        r_acc <= i_mac_y;
                        r_cnt <= w_cnt_inc[LEN_W-1:0];
                        if (w_cnt_inc == {1'b0, r_len}) begin
                            r_state  <= DONE;
                            r_done   <= 1'b1;
                            r_result <= i_mac_y;
                        end else begin
                            r_state    <= ISSUE;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_in_ready = r_in_ready;
    assign o_mac_a    = r_mac_a;
    assign o_mac_b    = r_mac_b;
    assign o_mac_c    = r_mac_c;
    assign o_done     = r_done;
    assign o_result   = r_result;

`ifdef FP_MAC_SEQ_PERF_EN
    logic [15:0] r_perf_cycles;
    logic [15:0] r_stall_cycles;

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_perf_cycles  <= '0;
            r_stall_cycles <= '0;
        end else if ((r_state == IDLE) && i_start) begin
            r_perf_cycles  <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (r_busy && (r_perf_cycles != 16'hFFFF)) begin
                r_perf_cycles <= r_perf_cycles + 16'd1;
            end
            if ((r_state == ISSUE) && !i_in_valid && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

    assign o_perf_cycles  = r_perf_cycles;
    assign o_stall_cycles = r_stall_cycles;
`else
    // Without the performance counters the block carries no extra state.
`endif

endmodule

// File: tb/tb_fp_mac_seq.sv
module tb_fp_mac_seq;
    import fp_mac_pkg::*;

    localparam int MAC_LAT = 4;
    localparam int LEN_W   = 8;

    logic        clock   = 1'b0;
    logic        resetn  = 1'b1;
    logic        start   = 1'b0;
    logic [7:0]  vec_len = '0;
    logic        in_valid = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        busy, in_ready, done;
    logic [15:0] mac_a, mac_b;
    logic [31:0] mac_c, mac_y, result;
`ifdef FP_MAC_SEQ_PERF_EN
    logic [15:0] perf_cycles, stall_cycles;
`endif

    always #5 clock = ~clock;

    fp_mac_seq #(.MAC_LAT(MAC_LAT), .LEN_W(LEN_W)) dut (
        .i_clock    (clock),
        .i_resetn   (resetn),
        .i_start    (start),
        .i_vec_len  (vec_len),
        .o_busy     (busy),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_in_a     (in_a),
        .i_in_b     (in_b),
        .o_mac_a    (mac_a),
        .o_mac_b    (mac_b),
        .o_mac_c    (mac_c),
        .i_mac_y    (mac_y),
        .o_done     (done),
        .o_result   (result)
`ifdef FP_MAC_SEQ_PERF_EN
        ,
        .o_perf_cycles  (perf_cycles),
        .o_stall_cycles (stall_cycles)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---- value helpers: only small non-negative integers are used ----
    function automatic int v16(input logic [15:0] h);
        case (h)
            16'h3C00: return 1;
            16'h4000: return 2;
            16'h4200: return 3;
            16'h4400: return 4;
            default:  return 0;
        endcase
    endfunction

    function automatic logic [31:0] i2f(input int n);
        int p;
        logic [31:0] m;
        if (n <= 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 24; i++) if (((n >> i) & 1) == 1) p = i;
        m = (32'(n) << (23 - p)) & 32'h007F_FFFF;
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    function automatic int f2i(input logic [31:0] f);
        int e;
        logic [23:0] m;
        if (f[30:0] == 31'h0) return 0;
        e = int'(f[30:23]) - 127;
        if (e < 0 || e > 23) return 0;
        m = {1'b1, f[22:0]};
        return int'(m >> (23 - e));
    endfunction

    // ---- fp_mac stand-in: Y = A*B + C, valid MAC_LAT edges after the load edge ----
    logic [31:0] pipe [0:MAC_LAT-2];
    always @(posedge clock) begin
        pipe[0] <= i2f(v16(mac_a) * v16(mac_b) + f2i(mac_c));
        for (int i = 1; i < MAC_LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign mac_y = pipe[MAC_LAT-2];

    // ---- behavioural reference model ----
    logic        m_busy = 0, m_ready = 0, m_done = 0, m_abort = 0;
    logic [31:0] m_result = 0, m_mac_c = 0;
    logic [15:0] m_mac_a = 0, m_mac_b = 0, m_perf = 0, m_stall = 0;
    int          m_sum = 0;
    logic        s_start, s_valid;
    logic [7:0]  s_len;
    logic [15:0] s_a, s_b;

    task automatic edge_();
        @(posedge clock);
        s_start = start; s_len = vec_len; s_valid = in_valid; s_a = in_a; s_b = in_b;
        if (!resetn) begin
            m_busy = 0; m_ready = 0; m_done = 0; m_result = 0;
            m_mac_a = 0; m_mac_b = 0; m_mac_c = 0; m_perf = 0; m_stall = 0;
            m_abort = 1;
            return;
        end
        if (m_busy && m_perf != 16'hFFFF) m_perf++;
        if (m_ready && !s_valid && m_stall != 16'hFFFF) m_stall++;
    endtask

    task automatic run_model();
        int len;
        len = int'(s_len);
        m_perf = 0; m_stall = 0; m_sum = 0; m_busy = 1;
        if (len == 0) begin
            m_ready = 0; m_done = 1; m_result = 0;
        end else begin
            for (int k = 0; k < len; k++) begin
                m_ready = 1;
                do begin
                    edge_();
                    if (m_abort) return;
                end while (!s_valid);
                m_mac_a = s_a; m_mac_b = s_b; m_mac_c = i2f(m_sum); m_ready = 0;
                repeat (MAC_LAT) begin
                    edge_();
                    if (m_abort) return;
                end
                m_sum += v16(m_mac_a) * v16(m_mac_b);
            end
            m_done = 1; m_result = i2f(m_sum);
        end
        edge_();
        if (m_abort) return;
        m_done = 0; m_busy = 0;
    endtask

    initial begin
        forever begin
            edge_();
            if (!m_abort && s_start) run_model();
            m_abort = 0;
        end
    end

    // ---- per-cycle compare ----
    bit chk_en = 0;
    always @(negedge clock) begin
        if (chk_en) begin
            chk("busy",     {31'b0, busy},     resetn ? {31'b0, m_busy}  : 32'h0);
            chk("in_ready", {31'b0, in_ready}, resetn ? {31'b0, m_ready} : 32'h0);
            chk("done",     {31'b0, done},     resetn ? {31'b0, m_done}  : 32'h0);
            chk("result",   result,            resetn ? m_result : 32'h0);
            chk("mac_a",    {16'b0, mac_a},    resetn ? {16'b0, m_mac_a} : 32'h0);
            chk("mac_b",    {16'b0, mac_b},    resetn ? {16'b0, m_mac_b} : 32'h0);
            chk("mac_c",    mac_c,             resetn ? m_mac_c : 32'h0);
`ifdef FP_MAC_SEQ_PERF_EN
            chk("perf_cycles",  {16'b0, perf_cycles},  resetn ? {16'b0, m_perf}  : 32'h0);
            chk("stall_cycles", {16'b0, stall_cycles}, resetn ? {16'b0, m_stall} : 32'h0);
`endif
        end
    end

    int done_cnt = 0;
    bit ready_seen = 0;
    always @(negedge clock) begin
        if (done) done_cnt++;
        if (in_ready) ready_seen = 1;
    end

    // ---- drivers (all called at a negedge) ----
    int start_cyc = 0;
    logic [31:0] macc_q[$];

    task automatic do_start(input int len, input bit hold);
        start = 1; vec_len = 8'(len);
        @(posedge clock);
        #1 start_cyc = cyc;
        @(negedge clock);
        if (!hold) start = 0;
        vec_len = 8'($urandom);
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        total++;
        if (guard >= 200) begin
            bad++;
            $display("FAIL ready_timeout: got in_ready=0 expected 1 within 200 cycles");
        end
    endtask

    task automatic feed(input logic [15:0] a, input logic [15:0] b, input int pre);
        if (pre > 0) begin
            wait_ready();
            repeat (pre) begin
                in_valid = 0;
                @(negedge clock);
            end
        end
        in_valid = 1; in_a = a; in_b = b;
        wait_ready();
        @(negedge clock);
        in_valid = 0; in_a = 16'($urandom); in_b = 16'($urandom);
        macc_q.push_back(mac_c);
    endtask

    task automatic wait_done(output int dcyc, output logic [31:0] res);
        int guard = 0;
        while (!done && guard < 2000) begin
            @(negedge clock);
            guard++;
        end
        total++;
        if (guard >= 2000) begin
            bad++;
            $display("FAIL done_timeout: got done=0 expected 1 within 2000 cycles");
        end
        dcyc = cyc - start_cyc + 1;
        res  = result;
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] tbl [0:4];
    initial begin
        int dc, d0, len, sum;
        logic [31:0] res;
        logic [15:0] a, b;
        tbl[0] = 16'h0000; tbl[1] = 16'h3C00; tbl[2] = 16'h4000;
        tbl[3] = 16'h4200; tbl[4] = 16'h4400;

        #1 resetn = 0;
        chk_en = 1;
        repeat (3) @(negedge clock);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_result", result, 32'h0);
        resetn = 1;
        @(negedge clock);

        // single element 1.0*1.0
        do_start(1, 0);
        feed(FP16_ONE, FP16_ONE, 0);
        wait_done(dc, res);
        chk("t1_result", res, 32'h3F80_0000);
        chk("t1_done_cycle", dc, 6);
        @(negedge clock);
        chk("t1_busy_after", {31'b0, busy}, 32'h0);
`ifdef FP_MAC_SEQ_PERF_EN
        chk("t1_perf", {16'b0, perf_cycles}, 32'd6);
`endif

        // 3 elements back to back: 1*2 + 2*2 + 3*2 = 12
        macc_q.delete();
        do_start(3, 0);
        feed(FP16_ONE, FP16_TWO, 0);
        feed(FP16_TWO, FP16_TWO, 0);
        feed(FP16_THREE, FP16_TWO, 0);
        wait_done(dc, res);
        chk("t2_result", res, 32'h4140_0000);
        chk("t2_done_cycle", dc, 16);
        chk("t2_mac_c0", macc_q[0], 32'h0000_0000);
        chk("t2_mac_c1", macc_q[1], 32'h4000_0000);
        chk("t2_mac_c2", macc_q[2], 32'h40C0_0000);
        @(negedge clock);

        // same vectors, 3 stall cycles before each pair
        do_start(3, 0);
        feed(FP16_ONE, FP16_TWO, 3);
        feed(FP16_TWO, FP16_TWO, 3);
        feed(FP16_THREE, FP16_TWO, 3);
        wait_done(dc, res);
        chk("t3_result", res, 32'h4140_0000);
        chk("t3_done_cycle", dc, 25);
`ifdef FP_MAC_SEQ_PERF_EN
        chk("t3_stall", {16'b0, stall_cycles}, 32'd9);
`endif
        @(negedge clock);

        // zero-length vector
        ready_seen = 0;
        do_start(0, 0);
        wait_done(dc, res);
        chk("t4_result", res, 32'h0);
        chk("t4_done_cycle", dc, 1);
        repeat (2) @(negedge clock);
        chk("t4_ready_never", {31'b0, ready_seen}, 32'h0);

        // reset during the second WAIT, then a fresh single-element run
        d0 = done_cnt;
        do_start(3, 0);
        feed(FP16_TWO, FP16_TWO, 0);
        feed(FP16_THREE, FP16_TWO, 0);
        @(posedge clock);
        #2 resetn = 0;
        #1;
        chk("t5_rst_busy",  {31'b0, busy},     32'h0);
        chk("t5_rst_ready", {31'b0, in_ready}, 32'h0);
        chk("t5_rst_mac_c", mac_c,             32'h0);
        chk("t5_rst_mac_a", {16'b0, mac_a},    32'h0);
        chk("t5_rst_result", result,           32'h0);
        repeat (2) @(negedge clock);
        resetn = 1;
        @(negedge clock);
        chk("t5_no_done", done_cnt, d0);
        do_start(1, 0);
        feed(FP16_TWO, FP16_THREE, 0);
        wait_done(dc, res);
        chk("t5_result", res, 32'h40C0_0000);
        chk("t5_done_cycle", dc, 6);
        @(negedge clock);

        // start held high for a whole run: 1*4 + 3*3 = 13
        d0 = done_cnt;
        do_start(2, 1);
        feed(FP16_ONE, 16'h4400, 0);
        feed(FP16_THREE, FP16_THREE, 0);
        wait_done(dc, res);
        start = 0;
        chk("t6_result", res, 32'h4150_0000);
        repeat (3) @(negedge clock);
        chk("t6_one_done", done_cnt - d0, 1);

        // longest vector: 255 x 1.0*1.0
        do_start(255, 0);
        for (int k = 0; k < 255; k++) feed(FP16_ONE, FP16_ONE, 0);
        wait_done(dc, res);
        chk("t7_result", res, 32'h437F_0000);
        chk("t7_done_cycle", dc, 1276);
        @(negedge clock);

        // randomized runs
        for (int r = 0; r < 30; r++) begin
            len = $urandom_range(0, 6);
            sum = 0;
            do_start(len, 0);
            for (int k = 0; k < len; k++) begin
                a = tbl[$urandom_range(0, 4)];
                b = tbl[$urandom_range(0, 4)];
                sum += v16(a) * v16(b);
                feed(a, b, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0);
            end
            wait_done(dc, res);
            chk("rand_result", res, i2f(sum));
            repeat ($urandom_range(1, 3)) @(negedge clock);
        end

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_mac_seq.md
Name: fp_mac_seq

Overview:
Dot-product sequencer for the fp_mac datapath. It accepts a stream of fp16 operand pairs over a valid/ready handshake, feeds them one at a time to fp_mac, and returns each fp_mac Y to fp_mac C as the running sum. Because fp_mac is pipelined, the block waits MAC_LAT cycles per element before issuing the next one. After vec_len elements it presents a single fp32 result with a one-cycle done pulse.

Parameters:
MAC_LAT, 4, cycles from the edge that loads the mac_a/mac_b/mac_c registers to the edge where mac_y is valid (multiplier + C buffer + adder); legal range 1..15
LEN_W, 8, width of vec_len and the element counter

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  begin a dot product; sampled only in IDLE
vec_len  in  LEN_W  element count, sampled on the start edge
busy  out  1  high in every state except IDLE
in_valid  in  1  operand pair valid
in_ready  out  1  high only in ISSUE
in_a  in  16  fp16 operand A
in_b  in  16  fp16 operand B
mac_a  out  16  to fp_mac A, registered
mac_b  out  16  to fp_mac B, registered
mac_c  out  32  to fp_mac C (running sum), registered
mac_y  in  32  from fp_mac Y
done  out  1  one-cycle pulse when result is valid
result  out  32  final fp32 sum; holds until the next start is accepted

Behaviour:
- Reset (asynchronous, any state): state=IDLE; mac_a, mac_b, mac_c, result, acc, cnt = 0; done, busy, in_ready = 0. Reset in the middle of an operation discards the partial sum with no done pulse.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - start=1 and vec_len!=0: acc=32'h0, cnt=0, result is held, go to ISSUE.
  - start=1 and vec_len==0: acc=32'h0, go to DONE.
- ISSUE:
  - in_ready=1.
  - On in_valid: load mac_a=in_a, mac_b=in_b, mac_c=acc; wait counter=MAC_LAT; go to WAIT.
  - Without in_valid: stay in ISSUE (stall for any number of cycles).
- WAIT:
  - in_ready=0. mac_a, mac_b and mac_c are held stable, because fp_mac samples C through its own buffer.
  - The counter decrements each cycle. On the edge where it goes 1->0: acc=mac_y, cnt=cnt+1.
  - If the new cnt==vec_len go to DONE, else go to ISSUE.
  - WAIT lasts exactly MAC_LAT cycles.
- DONE: done=1 for exactly one cycle; result=acc on entry; next state is IDLE.
- mac_a, mac_b and mac_c keep their last values outside WAIT. They change only on an accepted pair.
- Throughput with in_valid held high: one element per MAC_LAT+1 cycles. With start sampled at edge 0, done is high in cycle 1+N*(MAC_LAT+1).
- start while busy is ignored; it is not queued.
- vec_len is latched at start, so changes during a run have no effect. cnt compares against the latched copy, and vec_len = 2^LEN_W-1 is handled without wrap.
- The block does no fp arithmetic. NaN and Inf values pass through fp_mac unchanged.

Optional Feature:
FP_MAC_SEQ_PERF_EN
- Defined: adds output perf_cycles[15:0].
  - Cleared on an accepted start; increments each cycle while busy.
  - Saturates at 16'hFFFF and holds its value after done.
  - Also adds output stall_cycles[15:0]: counts ISSUE cycles with in_valid=0, with the same clear and saturation rules.
- Undefined: neither port exists and there is no counter logic.

Decomposition:
- Package fp_mac_pkg holds:
  - FP16_W=16, FP32_W=32
  - FP32_ZERO=32'h0000_0000
  - the state enum {IDLE, ISSUE, WAIT, DONE}
  - fp16/fp32 constants used by benches: 16'h3C00=1.0, 16'h4000=2.0, 16'h4200=3.0
- Natural sub-module: mac_lat_timer, a load/countdown counter with an expire flag. The FSM, accumulator register and length counter stay in fp_mac_seq.

Test Plan:
- MAC_LAT=4, start with vec_len=1, pair (3C00, 3C00), in_valid high -> result=32'h3F80_0000 (1.0); done in cycle 6; busy low afterwards.
- vec_len=3, A={3C00, 4000, 4200}, B={4000, 4000, 4000} -> result=32'h4140_0000 (12.0); done in cycle 16; mac_c sequence 0, 2.0, 6.0.
- Same vectors with in_valid low for 3 cycles before each pair -> same result; done in cycle 25; mac ports stable throughout every WAIT; with the perf macro, stall_cycles=9.
- start with vec_len=0 -> done in cycle 1, result=0, in_ready never high.
- resetn low during the second WAIT of a 3-element run, then a fresh vec_len=1 run -> outputs 0 immediately; no done; the new result is correct with no leftover partial sum.
- start held high during a run -> ignored; exactly one done per accepted start.
